// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/select and result/flag bundle for the registered ALU
interface alu_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   full_result;
  logic             k;
  logic             n;
  logic             c;
  logic             v;

  modport master (
    output a, b, sel,
    input  y, full_result, k, n, c, v
  );

  modport slave (
    input  a, b, sel,
    output y, full_result, k, n, c, v
  );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - registered add/sub/and/or unit with zero/negative/carry/overflow flags
module alu #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [WIDTH:0]   full_d;
  logic [WIDTH-1:0] y_d;
  logic             c_d;
  logic             v_d;

  always_comb begin
    full_d = '0;
    c_d    = 1'b0;
    v_d    = 1'b0;
    case (bus.sel)
      OP_ADD: full_d = {1'b0, bus.a} + {1'b0, bus.b};
      // Subtract as a + ~b + 1 so carry-out means "no borrow".
      OP_SUB: full_d = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
      OP_AND: full_d = {1'b0, bus.a & bus.b};
      OP_OR:  full_d = {1'b0, bus.a | bus.b};
      default: full_d = '0;
    endcase
    y_d = full_d[WIDTH-1:0];
    if (bus.sel == OP_ADD) begin
      c_d = full_d[WIDTH];
      v_d = (bus.a[MSB] == bus.b[MSB]) & (y_d[MSB] != bus.a[MSB]);
    end else if (bus.sel == OP_SUB) begin
      c_d = full_d[WIDTH];
      v_d = (bus.a[MSB] != bus.b[MSB]) & (y_d[MSB] != bus.a[MSB]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y           <= '0;
      bus.full_result <= '0;
      bus.k           <= 1'b0;
      bus.n           <= 1'b0;
      bus.c           <= 1'b0;
      bus.v           <= 1'b0;
    end else begin
      bus.y           <= y_d;
      bus.full_result <= full_d;
      bus.k           <= (y_d == '0);
      bus.n           <= y_d[MSB];
      bus.c           <= c_d;
      bus.v           <= v_d;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for the registered ALU
module tb_alu;
  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  logic [3:0] prev_y;

  alu_if #(.WIDTH(4)) bus ();

  alu #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ey, input logic [4:0] ef,
                         input logic [3:0] eflags);
    chk({tag, " y"},     {4'b0, bus.y},           {4'b0, ey});
    chk({tag, " full"},  {3'b0, bus.full_result}, {3'b0, ef});
    chk({tag, " kncv"},  {4'b0, bus.k, bus.n, bus.c, bus.v}, {4'b0, eflags});
  endtask

  // Drive away from the edge, confirm the old result still holds, then check one edge later.
  task automatic step(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                      input logic [1:0] ts, input logic [3:0] ey, input logic [4:0] ef,
                      input logic [3:0] eflags);
    @(negedge clk);
    bus.a   = ta;
    bus.b   = tb_v;
    bus.sel = ts;
    #1;
    chk({tag, " hold"}, {4'b0, bus.y}, {4'b0, prev_y});
    @(posedge clk);
    #1;
    chk_out(tag, ey, ef, eflags);
    prev_y = ey;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    prev_y     = 4'b0000;
    rst_n      = 1'b0;
    bus.a      = 4'b0111;
    bus.b      = 4'b0001;
    bus.sel    = 2'b00;

    #2;
    chk_out("reset", 4'b0000, 5'b00000, 4'b0000);
    @(posedge clk);
    #1;
    chk_out("reset_held", 4'b0000, 5'b00000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("released_no_edge", 4'b0000, 5'b00000, 4'b0000);
    @(posedge clk);
    #1;
    chk_out("first_edge", 4'b1000, 5'b01000, 4'b0101);
    prev_y = 4'b1000;

    step("add_wrap",   4'b1111, 4'b0001, 2'b00, 4'b0000, 5'b10000, 4'b1010);
    step("add_ovf",    4'b0111, 4'b0001, 2'b00, 4'b1000, 5'b01000, 4'b0101);
    step("sub_ovf",    4'b1000, 4'b0001, 2'b01, 4'b0111, 5'b10111, 4'b0011);
    step("sub_pos",    4'b0101, 4'b0011, 2'b01, 4'b0010, 5'b10010, 4'b0010);
    step("sub_borrow", 4'b0011, 4'b0101, 2'b01, 4'b1110, 5'b01110, 4'b0100);
    step("sub_equal",  4'b0101, 4'b0101, 2'b01, 4'b0000, 5'b10000, 4'b1010);
    step("and",        4'b1100, 4'b1010, 2'b10, 4'b1000, 5'b01000, 4'b0100);
    step("or_zero",    4'b0000, 4'b0000, 2'b11, 4'b0000, 5'b00000, 4'b1000);

    // sel changes every cycle on fixed operands
    step("lat_add",    4'b0110, 4'b0011, 2'b00, 4'b1001, 5'b01001, 4'b0101);
    step("lat_sub",    4'b0110, 4'b0011, 2'b01, 4'b0011, 5'b10011, 4'b0010);
    step("lat_and",    4'b0110, 4'b0011, 2'b10, 4'b0010, 5'b00010, 4'b0000);
    step("lat_or",     4'b0110, 4'b0011, 2'b11, 4'b0111, 5'b00111, 4'b0000);

    // mid-run asynchronous reset, asserted between edges
    step("pre_reset",  4'b1111, 4'b0001, 2'b00, 4'b0000, 5'b10000, 4'b1010);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 4'b0000, 5'b00000, 4'b0000);
    @(negedge clk);
    rst_n   = 1'b1;
    bus.a   = 4'b0011;
    bus.b   = 4'b0101;
    bus.sel = 2'b01;
    @(posedge clk);
    #1;
    chk_out("after_reset", 4'b1110, 5'b01110, 4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
